// File: rtl/shift_pkg.sv
// shift_pkg: shared types and default width for the iterative shifter.
package shift_pkg;
   localparam int WIDTH = 32;
   typedef enum logic [1:0] {SH_LSL = 2'd0, SH_LSR = 2'd1, SH_ASR = 2'd2, SH_ROR = 2'd3} shift_type_e;
   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_e;
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-position shift/rotate with the bit shifted out.
module shift_step
   import shift_pkg::*;
#(
   parameter int W = WIDTH
) (
   input  shift_type_e    sh_type,
   input  logic [W-1:0]   d,
   output logic [W-1:0]   d_next,
   output logic           carry
);
   logic fill;
   always_comb begin
      fill   = (sh_type == SH_ASR) ? d[W-1] : (sh_type == SH_ROR) ? d[0] : 1'b0;
      d_next = (sh_type == SH_LSL) ? {d[W-2:0], 1'b0} : {fill, d[W-1:1]};
      carry  = (sh_type == SH_LSL) ? d[W-1] : d[0];
   end
endmodule

// File: rtl/shift_iter.sv
// shift_iter: multi-cycle shifter, one bit position per clock, valid/ready on both sides.
// Define SHIFT_ITER_CARRY_EN to build the registered carry_out; otherwise it is tied to 0.
module shift_iter
   import shift_pkg::*;
#(
   parameter int WIDTH = shift_pkg::WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       shift_type,
   input  logic [CNT_W-1:0] shift_number,
   input  logic [WIDTH-1:0] reg_data,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] shift_out,
   output logic             carry_out
);
   state_e           state_q, state_d;
   shift_type_e      type_q, type_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] data_q, data_d, step_d;
   logic             step_c;
   logic             accept;

   shift_step #(.W(WIDTH)) u_step (
      .sh_type (type_q),
      .d       (data_q),
      .d_next  (step_d),
      .carry   (step_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         type_q  <= SH_LSL;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         type_q  <= type_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
      end
   end

   // abort wins over everything; in DONE it lands in IDLE either way
   always_comb begin
      accept  = (state_q == ST_IDLE) && in_valid && !abort;
      state_d = state_q;
      type_d  = type_q;
      cnt_d   = cnt_q;
      data_d  = data_q;
      if (abort) state_d = ST_IDLE;
      else begin
         case (state_q)
            ST_IDLE: if (in_valid) begin
               type_d  = shift_type_e'(shift_type);
               cnt_d   = shift_number;
               data_d  = reg_data;
               state_d = (shift_number == '0) ? ST_DONE : ST_SHIFT;
            end
            ST_SHIFT: begin
               data_d  = step_d;
               cnt_d   = cnt_q - 1'b1;
               state_d = (cnt_q == CNT_W'(1)) ? ST_DONE : ST_SHIFT;
            end
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
         endcase
      end
   end

`ifdef SHIFT_ITER_CARRY_EN
   logic carry_q, carry_d;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) carry_q <= 1'b0;
      else        carry_q <= carry_d;
   end
   always_comb begin
      carry_d = accept ? 1'b0 : (!abort && state_q == ST_SHIFT) ? step_c : carry_q;
   end
   assign carry_out = carry_q;
`else
   logic unused_c;
   assign unused_c  = step_c ^ accept;
   assign carry_out = 1'b0;
`endif

   always_comb begin
      in_ready  = (state_q == ST_IDLE);
      out_valid = (state_q == ST_DONE);
      shift_out = data_q;
   end
endmodule
